// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: RISC-V load/store
// funct3 codes, arbiter FSM states and access-size codes used by the
// alignment check.
package mem_port_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] selects the access size; only half and word need alignment
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Starvation counter width, large enough for STARVE_LIMIT up to 15
    localparam int unsigned STARVE_W = 4;

    typedef enum logic {
        ST_DATA_PRI = 1'b0,
        ST_IF_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_align_check.sv
// Flags a data access whose byte address is not naturally aligned to its
// size. Byte accesses are always aligned.
module mem_port_arbiter_align_check
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] size_code,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    // Half needs addr[0]=0, word needs addr[1:0]=0
    always_comb begin
        misaligned = 1'b0;
        if (size_code == SZ_WORD)
            misaligned = (addr_lo != 2'b00);
        else if (size_code == SZ_HALF)
            misaligned = addr_lo[0];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter in front of the single-port unified memory. The MEM stage has
// priority; IF gets the port when data is idle or misaligned, and a
// starvation counter forces one IF cycle after STARVE_LIMIT denials.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_grant,
    output logic [31:0]       if_instr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_grant,
    output logic [31:0]       d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              misalign,
    output logic [31:0]       misalign_addr,
    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_t          state, state_nxt;
    logic [STARVE_W-1:0] starve_cnt, starve_nxt, starve_inc;
    logic                data_present, data_bad_align, data_mis, data_valid;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    mem_port_arbiter_align_check u_align (
        .size_code  (d_funct3[1:0]),
        .addr_lo    (d_addr[1:0]),
        .misaligned (data_bad_align)
    );

    assign data_present = d_read | d_write;
    assign data_mis     = data_present & data_bad_align;
    assign data_valid   = data_present & ~data_bad_align;
    assign starve_inc   = starve_cnt + STARVE_W'(1);

    // State, starvation counter, misalign capture and conflict counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_DATA_PRI;
            starve_cnt    <= '0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            conflict_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            misalign   <= data_mis;
            if (data_mis)
                misalign_addr <= d_addr;
            if (if_req && data_present && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // Port arbitration, memory steering and next-state selection
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        if_grant   = 1'b0;
        if_instr   = '0;
        d_grant    = 1'b0;
        d_rdata    = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            // A misaligned access is consumed without touching memory
            if (data_mis) begin
                d_grant    = 1'b1;
                starve_nxt = '0;
            end
            if (data_valid && state == ST_DATA_PRI) begin
                d_grant    = 1'b1;
                mem_write  = d_write;
                mem_read   = d_read & ~d_write;
                mem_funct3 = d_funct3;
                mem_addr   = d_addr[ADDR_W+1:2];
                mem_wdata  = d_wdata;
                if (d_read && !d_write)
                    d_rdata = mem_rdata;
                if (if_req) begin
                    if (starve_inc == STARVE_W'(STARVE_LIMIT)) begin
                        state_nxt  = ST_IF_FORCE;
                        starve_nxt = '0;
                    end else begin
                        starve_nxt = starve_inc;
                    end
                end
            end else begin
                // Memory is free for IF: idle/misaligned data, or forced IF cycle
                if (if_req) begin
                    if_grant   = 1'b1;
                    mem_read   = 1'b1;
                    mem_funct3 = F3_LW;
                    mem_addr   = if_addr[ADDR_W+1:2];
                    if_instr   = mem_rdata;
                end
                state_nxt  = ST_DATA_PRI;
                starve_nxt = '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, a
// starvation sequence, then randomized traffic against a reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_grant;
    logic [31:0] if_instr;
    logic        d_read, d_write;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_grant;
    logic [31:0] d_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic [15:0] conflict_cnt;

    logic [31:0] tb_mem [64];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];

    mem_port_arbiter #(.ADDR_W(6), .STARVE_LIMIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_instr(if_instr),
        .d_read(d_read), .d_write(d_write), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_grant(d_grant), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .misalign(misalign), .misalign_addr(misalign_addr), .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] d_addr, d_wdata;
        logic        e_ig;
        logic [31:0] e_instr;
        logic        e_dg;
        logic [31:0] e_rdata;
        logic        e_mr, e_mw;
        logic [2:0]  e_f3;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        logic        chk_reg, e_mis;
        logic [31:0] e_mis_addr;
        logic [15:0] e_conf;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic rd,
                         input logic wr, input logic [2:0] f3, input logic [31:0] da,
                         input logic [31:0] wd);
        rst = r; if_req = ir; if_addr = ia; d_read = rd; d_write = wr;
        d_funct3 = f3; d_addr = da; d_wdata = wd;
    endtask

    task automatic set_in(input int i, input logic r, input logic ir, input logic [31:0] ia,
                          input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] da, input logic [31:0] wd);
        vt[i].rst = r; vt[i].if_req = ir; vt[i].if_addr = ia; vt[i].rd = rd; vt[i].wr = wr;
        vt[i].f3 = f3; vt[i].d_addr = da; vt[i].d_wdata = wd;
    endtask

    task automatic set_exp(input int i, input logic ig, input logic [31:0] instr, input logic dg,
                           input logic [31:0] rdata, input logic mr, input logic mw,
                           input logic [2:0] f3, input logic [5:0] a, input logic [31:0] wd,
                           input logic chk, input logic mis, input logic [31:0] mis_a,
                           input logic [15:0] conf);
        vt[i].e_ig = ig; vt[i].e_instr = instr; vt[i].e_dg = dg; vt[i].e_rdata = rdata;
        vt[i].e_mr = mr; vt[i].e_mw = mw; vt[i].e_f3 = f3; vt[i].e_addr = a; vt[i].e_wdata = wd;
        vt[i].chk_reg = chk; vt[i].e_mis = mis; vt[i].e_mis_addr = mis_a; vt[i].e_conf = conf;
    endtask

    // Compare every output against one expected record; bus fields only when strobed
    task automatic compare(input string tag, input vec_t v);
        check({tag, ".if_grant"}, 32'(if_grant), 32'(v.e_ig));
        check({tag, ".if_instr"}, if_instr, v.e_instr);
        check({tag, ".d_grant"}, 32'(d_grant), 32'(v.e_dg));
        check({tag, ".d_rdata"}, d_rdata, v.e_rdata);
        check({tag, ".mem_read"}, 32'(mem_read), 32'(v.e_mr));
        check({tag, ".mem_write"}, 32'(mem_write), 32'(v.e_mw));
        if (v.e_mr || v.e_mw) begin
            check({tag, ".mem_funct3"}, 32'(mem_funct3), 32'(v.e_f3));
            check({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        end
        if (v.e_mw)
            check({tag, ".mem_wdata"}, mem_wdata, v.e_wdata);
        if (v.chk_reg) begin
            check({tag, ".misalign"}, 32'(misalign), 32'(v.e_mis));
            check({tag, ".misalign_addr"}, misalign_addr, v.e_mis_addr);
            check({tag, ".conflict_cnt"}, 32'(conflict_cnt), 32'(v.e_conf));
        end
    endtask

    // Reference model state: plain counters and flags
    int          m_starve;
    bit          m_force;
    int          m_conf;
    bit          m_mis;
    logic [31:0] m_mis_addr;

    task automatic model_reset();
        m_starve = 0; m_force = 0; m_conf = 0; m_mis = 0; m_mis_addr = '0;
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model
    task automatic model_cycle(output vec_t e);
        bit present, mis, valid, data_mem;
        e = '{default: '0};
        e.chk_reg = 1'b1;
        e.e_mis = m_mis; e.e_mis_addr = m_mis_addr; e.e_conf = 16'(m_conf);
        if (rst) begin
            model_reset();
            return;
        end
        present  = d_read || d_write;
        mis      = present && ((d_funct3[1:0] == 2'd2 && d_addr[1:0] != 2'd0) ||
                               (d_funct3[1:0] == 2'd1 && d_addr[0]));
        valid    = present && !mis;
        data_mem = valid && !m_force;
        e.e_dg   = mis || data_mem;
        if (data_mem) begin
            e.e_mw = d_write; e.e_mr = d_read && !d_write;
            e.e_f3 = d_funct3; e.e_addr = d_addr[7:2]; e.e_wdata = d_wdata;
            if (d_read && !d_write) e.e_rdata = tb_mem[d_addr[7:2]];
        end else if (if_req) begin
            e.e_ig = 1'b1; e.e_mr = 1'b1; e.e_f3 = 3'b010; e.e_addr = if_addr[7:2];
            e.e_instr = tb_mem[if_addr[7:2]];
        end
        if (if_req && present && m_conf < 65535) m_conf++;
        if (mis) m_mis_addr = d_addr;
        m_mis = mis;
        if (data_mem) begin
            m_force = 0;
            if (if_req) begin
                m_starve++;
                if (m_starve == 4) begin m_force = 1; m_starve = 0; end
            end
        end else begin
            m_force = 0; m_starve = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h5A000000 + 32'(i) * 32'h00010001;
        tb_mem[2] = 32'hAABBCCDD;

        // Directed table: inputs then expected outputs
        set_in(0, 1, 1, 32'h0, 1, 0, 3'b010, 32'h0, 32'h0);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        set_in(1, 0, 1, 32'h08, 0, 0, 3'b000, 32'h0, 32'h0);
        set_exp(1, 1, 32'hAABBCCDD, 0, 0, 1, 0, 3'b010, 6'd2, 0, 1, 0, 0, 0);
        set_in(2, 0, 1, 32'h10, 1, 0, 3'b010, 32'h0A, 32'h0);
        set_exp(2, 1, tb_mem[4], 1, 0, 1, 0, 3'b010, 6'd4, 0, 1, 0, 0, 0);
        set_in(3, 0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        set_exp(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0A, 1);
        set_in(4, 0, 0, 32'h0, 0, 1, 3'b001, 32'h06, 32'h1234);
        set_exp(4, 0, 0, 1, 0, 0, 1, 3'b001, 6'd1, 32'h1234, 1, 0, 32'h0A, 1);
        set_in(5, 0, 0, 32'h0, 1, 1, 3'b000, 32'h03, 32'h55);
        set_exp(5, 0, 0, 1, 0, 0, 1, 3'b000, 6'd0, 32'h55, 1, 0, 32'h0A, 1);
        set_in(6, 0, 0, 32'h0, 1, 0, 3'b010, 32'h0C, 32'h0);
        set_exp(6, 0, 0, 1, tb_mem[3], 1, 0, 3'b010, 6'd3, 0, 1, 0, 32'h0A, 1);
        set_in(7, 0, 0, 32'h0, 1, 0, 3'b001, 32'h05, 32'h0);
        set_exp(7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0A, 1);
        set_in(8, 0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        set_exp(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h05, 1);
        set_in(9, 0, 0, 32'h0, 1, 0, 3'b100, 32'h07, 32'h0);
        set_exp(9, 0, 0, 1, tb_mem[1], 1, 0, 3'b100, 6'd1, 0, 1, 0, 32'h05, 1);
        set_in(10, 1, 1, 32'h0, 0, 1, 3'b010, 32'h0, 32'hDEAD);
        set_exp(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(11, 0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        set_exp(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].rst, vt[i].if_req, vt[i].if_addr, vt[i].rd, vt[i].wr,
                  vt[i].f3, vt[i].d_addr, vt[i].d_wdata);
            @(negedge clk);
            compare($sformatf("vec%0d", i), vt[i]);
            @(posedge clk); #1;
        end

        // Starvation: IF and lw@0 held together for 10 cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            drive(0, 1, 32'h08, 1, 0, 3'b010, 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("starve%0d.d_grant", c), 32'(d_grant), 32'((c == 4 || c == 9) ? 0 : 1));
            check($sformatf("starve%0d.if_grant", c), 32'(if_grant), 32'((c == 4 || c == 9) ? 1 : 0));
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("starve.conflict_cnt", 32'(conflict_cnt), 32'd10);
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            vec_t e;
            logic [2:0] f3s [5];
            f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  32'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), f3s[$urandom_range(0, 4)],
                  32'($urandom_range(0, 255)), $urandom);
            @(negedge clk);
            model_cycle(e);
            compare($sformatf("rand%0d", n), e);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the unified single-port data/instruction memory in the single-memory pipeline.
- Arbitrates each cycle between the IF stage (instruction fetch) and the MEM stage (load/store), and drives the memory's MemRead/MemWrite/function3/addr/data_in.
- Converts byte addresses to word indices and blocks misaligned data accesses.
- Guarantees fetch forward progress with a starvation counter, and counts port conflicts for performance analysis.

Parameters:
- ADDR_W, 6, memory word-index width (64 words).
- STARVE_LIMIT, 4, consecutive IF-denied cycles before one forced IF grant (range 1..15).
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF stage requests a fetch.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_grant  out  1  fetch performed this cycle.
- if_instr  out  32  fetched word, valid when if_grant=1, else 0.
- d_read  in  1  MEM stage load.
- d_write  in  1  MEM stage store.
- d_funct3  in  3  RISC-V load/store funct3.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_grant  out  1  data request consumed this cycle.
- d_rdata  out  32  load data when d_grant and d_read, else 0.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_funct3  out  3  to memory function3.
- mem_addr  out  ADDR_W  to memory word address.
- mem_wdata  out  32  to memory data_in.
- mem_rdata  in  32  from memory data_out (combinational).
- misalign  out  1  registered one-cycle pulse, data access misaligned.
- misalign_addr  out  32  captured d_addr of last misaligned access.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests present.

Behaviour:
- Reset values: all outputs 0. While rst=1, grants and mem strobes are forced 0; state returns to DATA_PRI; counters are cleared. A reset mid-access aborts the access, and no write occurs.
- Request and alignment rules:
  - A data request is present when d_read|d_write.
  - If d_write and d_read are both high, it is treated as a write: mem_read=0.
  - A data request is misaligned when funct3[1:0]=10 and d_addr[1:0]!=0, or funct3[1:0]=01 and d_addr[0]=1. Byte accesses are never misaligned.
  - A data request is valid when present and aligned.
- FSM states: DATA_PRI and IF_FORCE.
- DATA_PRI:
  - Valid data request: d_grant=1, memory driven from the data side (mem_addr=d_addr[ADDR_W+1:2], mem_funct3=d_funct3, mem_wdata=d_wdata). If if_req is also high: starve_cnt+1; when this reaches STARVE_LIMIT, go to IF_FORCE and clear starve_cnt.
  - No valid data request: if if_req, then if_grant=1, mem_read=1, mem_funct3=010, mem_addr=if_addr[ADDR_W+1:2]. starve_cnt is cleared.
- IF_FORCE:
  - if_grant=if_req and d_grant=0; the MEM stage stalls.
  - Next state is always DATA_PRI, even if if_req has dropped.
- Misaligned data request (either state):
  - d_grant=1 (consumed, not stalled); memory strobes are not driven for data; d_rdata=0.
  - Next cycle: misalign=1 and misalign_addr=d_addr.
  - IF may use the memory that same cycle.
  - starve_cnt is cleared.
- Datapath: everything is combinational in the same cycle (0 latency). if_instr and d_rdata are taken from mem_rdata.
- conflict_cnt: increments each cycle that if_req and a present data request coincide; saturates at all-ones.

Decomposition:
- Shared package/defines file: funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW), FSM state encodings, misalignment check constants.
- One natural sub-module: align_check (combinational: funct3 plus addr[1:0] to misaligned flag).

Test Plan:
- Reset: rst=1 with if_req=d_read=1 → grants=0, mem_read=mem_write=0, conflict_cnt=0. Release rst → DATA_PRI behaviour from the next cycle.
- IF only: if_req=1, if_addr=0x08, memory word 2=0xAABBCCDD → mem_addr=2, mem_funct3=010, if_grant=1, if_instr=0xAABBCCDD.
- Starvation with STARVE_LIMIT=4: if_req and d_read (lw at 0x0) held for 10 cycles → d_grant on cycles 0-3 and 5-8, if_grant on cycles 4 and 9. conflict_cnt=10 afterwards.
- Misaligned: lw at d_addr=0x0A with if_req=1 → d_grant=1, if_grant=1, mem_read for IF only, d_rdata=0. Next cycle misalign=1 and misalign_addr=0x0A; the cycle after, misalign=0.
- Aligned store: sh, d_addr=0x06, d_wdata=0x1234 → mem_write=1, mem_addr=1, mem_funct3=001, mem_wdata=0x1234, misalign stays 0.
- Read and write both high (sb at 0x03): mem_write=1, mem_read=0, d_rdata=0, d_grant=1.
